// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: arbiter state encodings and the default mid-packet stall limit.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // 1 ms at the 12 MHz board clock
    localparam int TIMEOUT_CYCLES_DEF = 12000;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// uart_arb_rr_pick: combinational round-robin picker; first valid index at or above the pointer, with wrap.
module uart_arb_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [REQ_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [REQ_W-1:0]   o_idx,
    output logic               o_any
);

    // Walk offsets from the far end down so the nearest valid index wins.
    always_comb begin
        logic [REQ_W-1:0] k;
        k        = '0;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = REQ_W'((int'(i_ptr) + i) % NUM_REQ);
            if (i_valid[k]) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = k;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX between NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to release a stalled owner after TIMEOUT_CYCLES and expose o_Timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef UART_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [NUM_REQ*8-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Busy
`ifdef UART_ARB_TIMEOUT_EN
    , output logic               o_Timeout
`endif
);

    localparam int REQ_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [REQ_W-1:0]     owner_q, owner_d;
    logic [REQ_W-1:0]     ptr_q, ptr_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 dv_q, dv_d;
    logic [7:0]           byte_q, byte_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [REQ_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 fire;
    logic                 rel;
    logic [REQ_W-1:0]     next_ptr;

    uart_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_valid  (i_Req_Valid),
        .i_ptr    (ptr_q),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    assign fire     = (state_q == ST_SEND) && i_Req_Valid[owner_q] && !i_TX_Active;
    assign rel      = (state_q == ST_WAIT) && i_TX_Done && last_q;
    assign next_ptr = (owner_q == REQ_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             stall;
    // The count restarts whenever SEND is (re)entered, so each byte gets a full window.
    assign stall = (state_q == ST_SEND) && !i_Req_Valid[owner_q];
    assign tmo_d = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d = (state_q != ST_SEND) ? '0 : stall ? cnt_q + 1'b1 : cnt_q;
    assign o_Timeout = tmo_q;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        ptr_d   = rel ? next_ptr : ptr_q;
        unique case (state_q)
            ST_IDLE: if (pick_any && !i_TX_Active) begin
                state_d = ST_SEND;
                owner_d = pick_idx;
            end
            ST_SEND: if (fire) begin
                state_d = ST_WAIT;
                last_d  = i_Req_Last[owner_q];
            end
            ST_WAIT: if (i_TX_Done) state_d = last_q ? ST_IDLE : ST_SEND;
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if (tmo_d) begin
            state_d = ST_IDLE;
            ptr_d   = next_ptr;
        end
`endif
    end

    always_comb begin
        grant_d = (state_d == ST_IDLE) ? '0 : (state_q == ST_IDLE) ? pick_onehot : grant_q;
        ready_d = fire ? NUM_REQ'(1) << owner_q : '0;
        dv_d    = fire;
        byte_d  = fire ? i_Req_Data[{owner_q, 3'b000} +: 8] : byte_q;
        busy_d  = state_d != ST_IDLE;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ready_q <= '0;
            dv_q    <= 1'b0;
            byte_q  <= 8'h00;
            busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign o_Grant     = grant_q;
    assign o_Req_Ready = ready_q;
    assign o_TX_DV     = dv_q;
    assign o_TX_Byte   = byte_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_l;
    logic [N-1:0]   valid, last, ready, grant;
    logic [N*8-1:0] data;
    logic           dv, tx_active, tx_done, busy;
    logic [7:0]     tx_byte;
`ifdef UART_ARB_TIMEOUT_EN
    logic           timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]   mem [N][64];
    int           head [N];
    int           tail [N];
    int           mp = 0;
    int           left = 0;
    bit           uart_auto = 1'b1;
    logic [7:0]   exp_b [$];
    logic [N-1:0] exp_g [$];
    logic [7:0]   got_b [$];
    logic [N-1:0] got_g [$];
    logic [N-1:0] got_r [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Req_Valid (valid),
        .i_Req_Data  (data),
        .i_Req_Last  (last),
        .o_Req_Ready (ready),
        .o_Grant     (grant),
        .o_TX_DV     (dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
        , .o_Timeout (timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic l, input logic [7:0] b);
        mem[k][tail[k]] = {l, b};
        tail[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            valid[k]       = head[k] < tail[k];
            data[k*8 +: 8] = mem[k][head[k]][7:0];
            last[k]        = mem[k][head[k]][8];
        end
    endtask

    // One clock: UART sink reacts to DV, requesters advance on Ready.
    task automatic step();
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        if (uart_auto) begin
            if (dv) begin
                check("dv while tx active", tx_active, 0);
                got_b.push_back(tx_byte);
                got_g.push_back(grant);
                got_r.push_back(ready);
                tx_active = 1'b1;
                left = $urandom_range(8, 2);
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++)
            if (ready[k] && head[k] < tail[k]) head[k]++;
        drive();
    endtask

    task automatic do_reset(input string tag);
        rst_l = 1'b0;
        step();
        step();
        check({tag, " grant"}, grant, 0);
        check({tag, " ready"}, ready, 0);
        check({tag, " dv"}, dv, 0);
        check({tag, " byte"}, tx_byte, 0);
        check({tag, " busy"}, busy, 0);
        rst_l = 1'b1;
        mp = 0;
    endtask

    // Whole packets in round-robin order over requesters with pending data.
    task automatic plan_stream();
        int  rd [N];
        bit  more;
        exp_b.delete(); exp_g.delete();
        got_b.delete(); got_g.delete(); got_r.delete();
        for (int k = 0; k < N; k++) rd[k] = head[k];
        do begin
            more = 1'b0;
            for (int o = 0; o < N; o++) begin
                int k;
                k = (mp + o) % N;
                if (rd[k] < tail[k]) begin
                    do begin
                        exp_b.push_back(mem[k][rd[k]][7:0]);
                        exp_g.push_back(N'(1) << k);
                        rd[k]++;
                    end while (!mem[k][rd[k]-1][8]);
                    mp = (k + 1) % N;
                    more = 1'b1;
                    break;
                end
            end
        end while (more);
        drive();
    endtask

    task automatic drain_stream(input string tag);
        for (int c = 0; c < 4000 && got_b.size() < exp_b.size(); c++) step();
        for (int c = 0; c < 50 && (grant != 0 || tx_active); c++) step();
        check({tag, " count"}, got_b.size(), exp_b.size());
        foreach (exp_b[i]) begin
            if (i < got_b.size()) begin
                check($sformatf("%s byte%0d", tag, i), got_b[i], exp_b[i]);
                check($sformatf("%s grant%0d", tag, i), got_g[i], exp_g[i]);
                check($sformatf("%s ready%0d", tag, i), got_r[i], exp_g[i]);
            end
        end
        check({tag, " idle grant"}, grant, 0);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0; valid = '0; last = '0; data = '0;
        tx_active = 1'b0; tx_done = 1'b0;
        for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
        do_reset("reset");

        // Single-byte packet with latency check
        push(0, 1'b1, 8'h41);
        plan_stream();
        step();
        check("lat c1 dv", dv, 0);
        check("lat c1 grant", grant, 4'b0001);
        check("lat c1 busy", busy, 1);
        step();
        check("lat c2 dv", dv, 1);
        check("lat c2 byte", tx_byte, 8'h41);
        step();
        check("lat c3 ready", ready, 0);
        drain_stream("one byte");

        // Packet lock: req2 waits for req1's whole packet
        push(1, 1'b0, 8'h48); push(1, 1'b1, 8'h49); push(2, 1'b1, 8'h5A);
        plan_stream();
        drain_stream("HI lock");

        do_reset("reset2");
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 1'b1, 8'(8'h30 + r * 4 + k));
        plan_stream();
        drain_stream("all valid");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                int np;
                np = $urandom_range(3, 0);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(3, 1);
                    for (int j = 0; j < len; j++) push(k, j == len - 1, 8'($urandom));
                end
            end
            plan_stream();
            drain_stream($sformatf("rand%0d", r));
        end

        // Reset while the UART is still serialising a byte
        push(0, 1'b0, 8'h76); push(0, 1'b1, 8'h77);
        got_b.delete(); got_g.delete(); got_r.delete();
        drive();
        for (int c = 0; c < 200 && got_b.size() < 1; c++) step();
        check("pre-reset byte", got_b.size() > 0 ? got_b[0] : 8'h00, 8'h76);
        uart_auto = 1'b0;
        tx_active = 1'b1;
        left = 0;
        do_reset("reset mid");
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("active hold dv%0d", c), dv, 0);
            check($sformatf("active hold grant%0d", c), grant, 0);
        end
        tx_active = 1'b0;
        uart_auto = 1'b1;
        plan_stream();
        drain_stream("after reset");

        // Owner stalls mid-packet
        begin
            int held_bad;
            held_bad = 0;
            push(1, 1'b0, 8'hA1); push(2, 1'b1, 8'hB2);
            got_b.delete(); got_g.delete(); got_r.delete();
            drive();
            for (int c = 0; c < 200 && got_b.size() < 1; c++) step();
            check("stall first byte", got_b.size() > 0 ? got_b[0] : 8'h00, 8'hA1);
            for (int c = 0; c < 50 && !tx_done; c++) step();
            check("stall done seen", tx_done, 1);
`ifdef UART_ARB_TIMEOUT_EN
            begin
                int tcyc, tcnt;
                tcyc = -1; tcnt = 0;
                for (int c = 1; c <= 20000; c++) begin
                    step();
                    if (timeout) begin
                        tcnt++;
                        if (tcyc < 0) tcyc = c;
                    end
                end
                check("timeout pulses", tcnt, 1);
                check("timeout near limit", (tcyc >= 11995 && tcyc <= 12010), 1);
                check("timeout count", got_b.size(), 2);
                check("timeout next byte", got_b.size() > 1 ? got_b[1] : 8'h00, 8'hB2);
                check("timeout next grant", got_g.size() > 1 ? got_g[1] : 4'h0, 4'b0100);
            end
`else
            for (int c = 0; c < 20000; c++) begin
                step();
                if (grant !== 4'b0010 || dv) held_bad++;
            end
            check("stall grant held", held_bad, 0);
            check("stall no bytes", got_b.size(), 1);
            push(1, 1'b1, 8'hA2);
            drive();
            for (int c = 0; c < 400 && got_b.size() < 3; c++) step();
            check("resume count", got_b.size(), 3);
            check("resume byte1", got_b.size() > 1 ? got_b[1] : 8'h00, 8'hA2);
            check("resume byte2", got_b.size() > 2 ? got_b[2] : 8'h00, 8'hB2);
            check("resume grant2", got_g.size() > 2 ? got_g[2] : 4'h0, 4'b0100);
`endif
            for (int c = 0; c < 50 && (grant != 0 || tx_active); c++) step();
            check("stall end grant", grant, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
